// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder at the target end of the core's
// load/store port. It accepts one request at a time, performs a word read or
// a byte-lane-masked write on an internal word array, waits WAIT_CYCLES
// cycles, and then returns a response.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-low reset
//   req_valid_i/ready_o   request handshake
//   req_we_i              1 = write, 0 = read
//   req_addr_i            byte address (BASE_ADDR maps to word 0)
//   req_be_i, req_wdata_i byte-lane enables and write data
//   resp_valid_o/ready_i  response handshake
//   resp_rdata_o          read data (0 for writes and errors)
//   resp_err_o            request rejected, no memory effect
//   dbg_state_o           current FSM state (IDLE=0, WAIT=1, RESP=2)
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both 1. Once valid is raised, the sender holds valid and its payload
// stable until that edge. req_ready_o does not depend on req_valid_i.
// resp_valid_o does not depend on resp_ready_i. Requests never overlap a
// pending response.
module dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [1:0]  dbg_state_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    wait_cnt;

  // Request captured on the accepting edge.
  logic          lat_we;
  logic [AW-1:0] lat_idx;
  logic [3:0]    lat_be;
  logic [31:0]   lat_wdata;
  logic          lat_err;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic          in_err;
  logic          accept;
  logic          in_idle;
  logic          cur_we;
  logic [AW-1:0] cur_idx;
  logic [3:0]    cur_be;
  logic [31:0]   cur_wdata;
  logic          cur_err;
  logic          enter_resp;
  logic          commit_write;

  // Gate ready with reset so it reads 0 while reset is asserted.
  assign req_ready_o  = rst_i && (state == ST_IDLE);
  assign resp_valid_o = (state == ST_RESP);
  assign dbg_state_o  = state;
  assign accept       = req_valid_i && req_ready_o;
  assign in_idle      = (state == ST_IDLE);

  // Modulo subtraction makes addresses below BASE_ADDR wrap to large offsets,
  // so one compare covers both ends of the window.
  assign off    = req_addr_i - BASE_ADDR;
  assign in_err = (off >= SPAN) || (req_we_i && (req_be_i == 4'b0000));

  // With zero wait states the commit happens on the accepting edge itself, so
  // the live request fields are used. Otherwise the latched copy is used.
  always_comb begin
    cur_we    = lat_we;
    cur_idx   = lat_idx;
    cur_be    = lat_be;
    cur_wdata = lat_wdata;
    cur_err   = lat_err;
    if (in_idle) begin
      cur_we    = req_we_i;
      cur_idx   = off[AW+1:2];
      cur_be    = req_be_i;
      cur_wdata = req_wdata_i;
      cur_err   = in_err;
    end
  end

  assign enter_resp = (in_idle && accept && (WAIT_CYCLES == 0)) ||
                      ((state == ST_WAIT) && (wait_cnt == 4'd0));
  assign commit_write = enter_resp && cur_we && !cur_err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      wait_cnt     <= 4'd0;
      lat_we       <= 1'b0;
      lat_idx      <= '0;
      lat_be       <= 4'b0000;
      lat_wdata    <= 32'h0;
      lat_err      <= 1'b0;
      resp_rdata_o <= 32'h0;
      resp_err_o   <= 1'b0;
    end else begin
      if (accept) begin
        lat_we    <= req_we_i;
        lat_idx   <= off[AW+1:2];
        lat_be    <= req_be_i;
        lat_wdata <= req_wdata_i;
        lat_err   <= in_err;
      end
      if (enter_resp) begin
        resp_err_o   <= cur_err;
        resp_rdata_o <= (cur_we || cur_err) ? 32'h0 : mem[cur_idx];
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The array has no reset; it keeps its contents across reset.
  always_ff @(posedge clk_i) begin
    if (commit_write) begin
      for (int n = 0; n < 4; n++) begin
        if (cur_be[n]) begin
          mem[cur_idx][8*n +: 8] <= cur_wdata[8*n +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp. Three instances run side by side with WAIT_CYCLES of
// 1, 0 and 3 (index 0, 1, 2). Each has its own reset and request/response
// signals, and all share one clock.
module tb_dmem_resp;

  localparam int WCS [3] = '{1, 0, 3};

  logic        clk;
  logic        rst_n      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [31:0] req_addr   [3];
  logic [3:0]  req_be     [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];
  logic [1:0]  dbg_state  [3];

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q [$];   // {err, rdata}

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_resp #(
      .DEPTH_WORDS(256),
      .BASE_ADDR  (32'h0000_0000),
      .WAIT_CYCLES(WCS[g])
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst_n[g]),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_we_i    (req_we[g]),
      .req_addr_i  (req_addr[g]),
      .req_be_i    (req_be[g]),
      .req_wdata_i (req_wdata[g]),
      .resp_valid_o(resp_valid[g]),
      .resp_ready_i(resp_ready[g]),
      .resp_rdata_o(resp_rdata[g]),
      .resp_err_o  (resp_err[g]),
      .dbg_state_o (dbg_state[g])
    );
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One full transaction on instance d. hold = cycles resp_ready stays 0 once
  // the response is valid. The expected {err, rdata} goes through exp_q.
  task automatic do_txn(input int d, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input logic [32:0] exp, input int hold, input string name);
    int n;
    logic got;
    logic [32:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    resp_ready[d] = 1'b0;
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_addr[d]   = addr;
    req_be[d]     = be;
    req_wdata[d]  = wdata;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      chk({name, " accept_timeout"}, 64'(req_ready[d]), 64'd1);
      req_valid[d] = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(posedge clk);
    #1;
    // Request fields are don't-care after acceptance; scramble them.
    req_valid[d] = 1'b0;
    req_we[d]    = 1'($urandom_range(0, 1));
    req_addr[d]  = $urandom();
    req_be[d]    = 4'($urandom_range(0, 15));
    req_wdata[d] = $urandom();
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = resp_valid[d];
    end
    chk({name, " latency"}, 64'(n), 64'(1 + WCS[d]));
    e = exp_q.pop_front();
    if (!got) return;
    chk({name, " resp"}, {31'h0, resp_err[d], resp_rdata[d]}, {31'h0, e});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, " hold"}, {29'h0, resp_valid[d], req_ready[d], resp_err[d], resp_rdata[d]},
          {29'h0, 1'b1, 1'b0, e});
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    chk({name, " idle"}, {29'h0, resp_valid[d], req_ready[d], resp_err[d], resp_rdata[d]},
        {29'h0, 1'b0, 1'b1, e});
    resp_ready[d] = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [15];
  logic [31:0] model_mem [256];
  bit          known     [256];

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
      req_be[d] = 4'h0; req_wdata[d] = 32'h0; resp_ready[d] = 1'b0;
    end
    for (int i = 0; i < 256; i++) known[i] = 1'b0;

    //            we    addr            be       wdata         err   rdata
    vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF,    32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'h0,    32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h0000_0020, 4'hF,    32'h11223344, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 4'b0001, 32'h000000AA, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0020, 4'b1000, 32'hBB000000, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0020, 4'hF,    32'h0,        1'b0, 32'hBB2233AA};
    vecs[6]  = '{1'b0, 32'h0000_0400, 4'hF,    32'h0,        1'b1, 32'h0};
    vecs[7]  = '{1'b1, 32'h0000_03FC, 4'hF,    32'h12345678, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_03FC, 4'h0,    32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_03FC, 4'h0,    32'h0,        1'b0, 32'h12345678};
    vecs[10] = '{1'b0, 32'hFFFF_FFFC, 4'h0,    32'h0,        1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_0013, 4'h0,    32'h0,        1'b0, 32'hDEADBEEF};
    vecs[12] = '{1'b1, 32'h0000_0022, 4'b0100, 32'h00CC0000, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h0000_0020, 4'h0,    32'h0,        1'b0, 32'hBBCC33AA};
    vecs[14] = '{1'b1, 32'h0000_0400, 4'hF,    32'h55555555, 1'b1, 32'h0};

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_out%0d", d),
          {60'h0, req_ready[d], resp_valid[d], resp_err[d], |resp_rdata[d]}, 64'h0);
    end
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("ready_after_reset%0d", d), {62'h0, req_ready[d], resp_valid[d]}, 64'h2);
    end

    // Table-driven vectors on the WAIT_CYCLES=1 instance.
    for (int i = 0; i < 15; i++) begin
      do_txn(0, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
             {vecs[i].err, vecs[i].rdata}, 0, $sformatf("vec%0d", i));
    end

    // Backpressure: hold resp_ready low for 5 cycles on a read.
    do_txn(0, 1'b0, 32'h0000_0010, 4'h0, 32'h0, {1'b0, 32'hDEADBEEF}, 5, "backpressure");

    // Random byte-lane traffic against a word-array model.
    for (int i = 0; i < 24; i++) begin
      int idx;
      logic [3:0] be;
      logic [31:0] wd;
      idx = $urandom_range(64, 79);
      if (!known[idx] || ($urandom_range(0, 1) == 1)) begin
        be = known[idx] ? 4'($urandom_range(1, 15)) : 4'hF;
        wd = $urandom();
        for (int n = 0; n < 4; n++) begin
          if (be[n]) model_mem[idx][8*n +: 8] = wd[8*n +: 8];
        end
        known[idx] = 1'b1;
        do_txn(0, 1'b1, 32'(idx * 4), be, wd, {1'b0, 32'h0}, 0, $sformatf("rand_wr%0d", i));
      end else begin
        do_txn(0, 1'b0, 32'(idx * 4 + $urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom(),
               {1'b0, model_mem[idx]}, 0, $sformatf("rand_rd%0d", i));
      end
    end

    // WAIT_CYCLES=0: back-to-back reads with req_valid and resp_ready held high.
    do_txn(1, 1'b1, 32'h0000_0040, 4'hF, 32'hCAFEF00D, {1'b0, 32'h0}, 0, "w0_write");
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h0000_0040;
    req_be[1] = 4'h0; resp_ready[1] = 1'b1;
    for (int t = 0; t < 8; t++) begin
      if (t % 2 == 0) begin
        chk($sformatf("b2b_idle%0d", t), {62'h0, req_ready[1], resp_valid[1]}, 64'h2);
      end else begin
        chk($sformatf("b2b_resp%0d", t),
            {29'h0, req_ready[1], resp_valid[1], resp_err[1], resp_rdata[1]},
            {29'h0, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D});
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    resp_ready[1] = 1'b0;
    do_txn(1, 1'b0, 32'h0000_0400, 4'h0, 32'h0, {1'b1, 32'h0}, 0, "w0_err");

    // WAIT_CYCLES=3: reset during the WAIT phase of a write drops it.
    do_txn(2, 1'b1, 32'h0000_0030, 4'hF, 32'h0000_0005, {1'b0, 32'h0}, 0, "w3_init");
    do_txn(2, 1'b0, 32'h0000_0030, 4'h0, 32'h0, {1'b0, 32'h5}, 0, "w3_read_before");
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h0000_0030;
    req_be[2] = 4'hF; req_wdata[2] = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("w3_in_wait", {62'h0, req_ready[2], resp_valid[2]}, 64'h0);
    rst_n[2] = 1'b0;
    #1;
    chk("w3_reset_out", {29'h0, req_ready[2], resp_valid[2], resp_err[2], resp_rdata[2]}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    @(negedge clk);
    chk("w3_ready_after_reset", 64'(req_ready[2]), 64'd1);
    do_txn(2, 1'b0, 32'h0000_0030, 4'h0, 32'h0, {1'b0, 32'h5}, 0, "w3_read_after");

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
Data-memory responder: the target end of the core's load/store port. It accepts one request at a time over a valid/ready handshake, then performs a word read or a byte-lane-masked write on an internal word array. It inserts a configurable number of wait states and returns a response over a second valid/ready handshake. It sits between the core's memory-request master and on-chip data RAM, replacing the zero-latency combinational dmem hookup.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; power of two.
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
WAIT_CYCLES, 1, wait states between request accept and response; range 0..15.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
req_valid_i  input  1  request valid
req_ready_o  output  1  responder can accept a request
req_we_i  input  1  1 = write, 0 = read
req_addr_i  input  32  byte address
req_be_i  input  4  byte-lane enables for writes; lane n = wdata[8n+7:8n]
req_wdata_i  input  32  write data
resp_valid_o  output  1  response valid
resp_ready_i  input  1  master accepts the response
resp_rdata_o  output  32  read data
resp_err_o  output  1  request was rejected; no memory effect

Behaviour:
- Reset (rst_i=0, asynchronous) forces:
  - state=IDLE, wait counter=0
  - req_ready_o=0 while rst_i=0, then 1 in IDLE
  - resp_valid_o=0, resp_rdata_o=0, resp_err_o=0
- Array contents are not cleared by reset.
- A request is accepted on a rising edge with req_valid_i=1 && req_ready_o=1.
  - The edge latches we, addr, be and wdata.
  - Inputs are don't-care after acceptance.
- FSM states:
  - IDLE: req_ready_o=1.
    - On accept with WAIT_CYCLES=0, go to RESP.
    - On accept with WAIT_CYCLES>0, go to WAIT and load counter=WAIT_CYCLES-1.
  - WAIT: req_ready_o=0.
    - Counter decrements each cycle.
    - At counter=0, go to RESP.
  - RESP: resp_valid_o=1, req_ready_o=0.
    - On resp_ready_i=1, go to IDLE.
    - Otherwise hold; all resp_* outputs stay stable.
- Memory effect and response data are committed on the edge that enters RESP.
- Latency: resp_valid_o rises exactly 1+WAIT_CYCLES cycles after the accepting edge.
- Throughput: at most one request per 2+WAIT_CYCLES cycles when resp_ready_i is held 1.
  - Requests are not accepted in the RESP exit cycle; there is no overlap.
- Address decode:
  - off = req_addr_i - BASE_ADDR (32-bit modulo).
  - idx = off[log2(DEPTH_WORDS)+1:2].
  - Out of range when off >= DEPTH_WORDS*4, including wrap below BASE_ADDR.
  - off[1:0] is ignored; the master aligns lanes via be.
- Read:
  - resp_rdata_o = full word mem[idx]; be is ignored.
  - resp_err_o=0.
- Write:
  - For each lane n with be[n]=1, mem[idx] byte n = wdata byte n; other lanes unchanged.
  - resp_rdata_o=0, resp_err_o=0.
- Error cases:
  - Cases: out-of-range address, or a write with be=4'b0000.
  - Response: no array change, resp_rdata_o=0, resp_err_o=1.
  - The error response follows the same latency and handshake as a normal response.
- Read-after-write: a read accepted after a write's response was taken returns the new data. No forwarding is needed because requests are not overlapped.
- resp_valid_o=0 outside RESP.
  - resp_rdata_o and resp_err_o keep the last response value while resp_valid_o=0.
- Reset mid-operation:
  - Any latched request is dropped.
  - A write still in WAIT is not committed.
  - A write already committed on entry to RESP remains.

Test Plan:
- Reset, WAIT_CYCLES=1:
  - Write addr 0x10, be 4'hF, data 0xDEADBEEF, accepted cycle 0 -> resp_valid_o=1 in cycle 2, err 0, rdata 0.
  - Read addr 0x10 -> rdata 0xDEADBEEF, err 0.
- Byte lanes:
  - Write 0x11223344 with be 4'hF to addr 0x20.
  - Write 0x000000AA with be 4'b0001, then 0xBB000000 with be 4'b1000.
  - Read 0x20 -> 0xBB2233AA.
- Backpressure: hold resp_ready_i=0 for 5 cycles during a read response -> resp_valid_o/rdata stay stable, req_ready_o=0 throughout. Response taken on the first cycle with resp_ready_i=1, then IDLE.
- Errors with DEPTH_WORDS=256:
  - Read 0x400 -> err 1, rdata 0.
  - Write 0x3FC with be 0 -> err 1, and a following read of 0x3FC returns the prior value.
- WAIT_CYCLES=0 back-to-back with req_valid_i held 1 -> accepts every 2 cycles, response 1 cycle after each accept.
- Reset asserted during WAIT of a write to 0x30, WAIT_CYCLES=3, where 0x30 previously held 0x5 -> all outputs 0 immediately; after release, read 0x30 returns 0x5.
